// File: rtl/and_unit_arbiter_if.sv
// ----------------------------------------------------------------------------
// and_unit_arbiter_if
//   Bundles the requester, datapath and response channels of the AND-unit
//   arbiter. The arbiter connects through the slave modport; the surrounding
//   pin logic, datapath and result consumer connect through the master modport.
//
//   Signals (directions as seen by the arbiter / slave modport):
//     req0_valid, req0_a, req0_b   in   requester 0 operand pair + valid
//     req0_ready                   out  requester 0 accepted this cycle
//     req1_valid, req1_a, req1_b   in   requester 1 operand pair + valid
//     req1_ready                   out  requester 1 accepted this cycle
//     dp_a, dp_b                   out  registered operands to the datapath
//     dp_busy                      out  datapath holds an in-flight operation
//     dp_y                         in   datapath result
//     rsp_valid, rsp_data, rsp_id  out  registered result and owner ID
//     rsp_ready                    in   consumer accepts result
// ----------------------------------------------------------------------------
interface and_unit_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic [WIDTH-1:0] dp_a;
    logic [WIDTH-1:0] dp_b;
    logic             dp_busy;
    logic [WIDTH-1:0] dp_y;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_id;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  dp_y,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output dp_a, dp_b, dp_busy,
        output rsp_valid, rsp_data, rsp_id
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output dp_y,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  dp_a, dp_b, dp_busy,
        input  rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/and_unit_arbiter.sv
// ----------------------------------------------------------------------------
// and_unit_arbiter
//   Round-robin arbiter/sequencer sharing one WIDTH-bit AND datapath between
//   two requesters. A granted operand pair is registered onto dp_a/dp_b, the
//   block waits LAT cycles for dp_y, then presents the registered result with
//   the owning requester ID on the response channel until it is accepted.
//   One operation is in flight at a time (at most one per LAT+2 cycles).
//
//   Parameters:
//     WIDTH  operand/result width in bits (must match the interface WIDTH)
//     LAT    datapath latency in cycles, LAT >= 1
//
//   Ports:
//     clk    in   system clock, rising edge
//     rst_n  in   asynchronous active-low reset
//     bus    --   and_unit_arbiter_if.slave: requester, datapath and
//                 response channels
//     busy   out  high whenever the sequencer is not idle
// ----------------------------------------------------------------------------
module and_unit_arbiter #(
    parameter int WIDTH = 8,
    parameter int LAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    and_unit_arbiter_if.slave    bus,
    output logic                 busy
);

    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state, state_n;
    logic             ptr, ptr_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] dp_a_q, dp_a_n;
    logic [WIDTH-1:0] dp_b_q, dp_b_n;
    logic             dp_busy_q, dp_busy_n;
    logic             rsp_valid_q, rsp_valid_n;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_n;
    logic             rsp_id_q, rsp_id_n;

    logic             grant_any;
    logic             grant_id;
    logic             ready0, ready1;

    // A lone requester wins regardless of the pointer; the pointer only
    // breaks ties when both are valid.
    assign grant_any = bus.req0_valid | bus.req1_valid;
    assign grant_id  = (bus.req0_valid & bus.req1_valid) ? ptr : bus.req1_valid;

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        cnt_n       = cnt;
        dp_a_n      = dp_a_q;
        dp_b_n      = dp_b_q;
        dp_busy_n   = dp_busy_q;
        rsp_valid_n = rsp_valid_q;
        rsp_data_n  = rsp_data_q;
        rsp_id_n    = rsp_id_q;
        ready0      = 1'b0;
        ready1      = 1'b0;

        unique case (state)
            IDLE: begin
                // ready is combinational, so it is gated by rst_n to keep
                // every output low while reset is held.
                if (grant_any && rst_n) begin
                    ready0    = ~grant_id;
                    ready1    = grant_id;
                    dp_a_n    = grant_id ? bus.req1_a : bus.req0_a;
                    dp_b_n    = grant_id ? bus.req1_b : bus.req0_b;
                    rsp_id_n  = grant_id;
                    ptr_n     = ~grant_id;
                    cnt_n     = CW'(LAT - 1);
                    dp_busy_n = 1'b1;
                    state_n   = WAIT;
                end
            end

            WAIT: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    rsp_data_n  = bus.dp_y;
                    rsp_valid_n = 1'b1;
                    dp_busy_n   = 1'b0;
                    state_n     = RESP;
                end
            end

            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= 1'b0;
            cnt         <= '0;
            dp_a_q      <= '0;
            dp_b_q      <= '0;
            dp_busy_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            cnt         <= cnt_n;
            dp_a_q      <= dp_a_n;
            dp_b_q      <= dp_b_n;
            dp_busy_q   <= dp_busy_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_data_q  <= rsp_data_n;
            rsp_id_q    <= rsp_id_n;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.dp_a       = dp_a_q;
    assign bus.dp_b       = dp_b_q;
    assign bus.dp_busy    = dp_busy_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_id     = rsp_id_q;
    assign busy           = (state != IDLE);

    // Structural invariants of the sequencer.
    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        !(ready0 && ready1));
    a_ready_only_idle: assert property (@(posedge clk) disable iff (!rst_n)
        (ready0 || ready1) |-> (state == IDLE));
    a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_valid_q && !bus.rsp_ready) |=>
            (rsp_valid_q && $stable(rsp_data_q) && $stable(rsp_id_q)));

endmodule

// File: tb/tb_and_unit_arbiter.sv
// ----------------------------------------------------------------------------
// tb_and_unit_arbiter
//   Two DUT lanes (LAT=1 and LAT=3), each with its own interface, a pipelined
//   AND datapath model and a transaction-level reference model that predicts
//   grants, operand capture, result timing and response contents.
// ----------------------------------------------------------------------------
module tb_and_unit_arbiter;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   mode;
    int   n_checks;
    int   n_errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int L = (g == 0) ? 1 : 3;

        and_unit_arbiter_if #(.WIDTH(W)) bus();
        logic busy;

        and_unit_arbiter #(.WIDTH(W), .LAT(L)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave),
            .busy  (busy)
        );

        // Datapath: result of operands that were stable at cycle start
        // appears L cycles later (L-1 register stages).
        if (L == 1) begin : g_dp_comb
            assign bus.dp_y = bus.dp_a & bus.dp_b;
        end else begin : g_dp_pipe
            logic [W-1:0] pipe [L-1];
            always @(posedge clk) begin
                pipe[0] <= bus.dp_a & bus.dp_b;
                for (int i = 1; i < L - 1; i++) pipe[i] <= pipe[i-1];
            end
            assign bus.dp_y = pipe[L-2];
        end

        string lt;
        initial lt = $sformatf("lat%0d", L);

        // Stimulus driver
        int stall;
        initial begin
            bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
            bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
            bus.rsp_ready  = 1'b0;
            stall = 0;
            forever begin
                @(posedge clk);
                #1;
                stall = bus.rsp_valid ? stall + 1 : 0;
                case (mode)
                    1: begin
                        bus.req0_valid = 1'b1; bus.req0_a = 8'hF0; bus.req0_b = 8'h3C;
                        bus.req1_valid = 1'b0;
                        bus.rsp_ready  = 1'b1;
                    end
                    2: begin
                        bus.req0_valid = 1'b1; bus.req0_a = 8'hFF; bus.req0_b = 8'h0F;
                        bus.req1_valid = 1'b1; bus.req1_a = 8'hAA; bus.req1_b = 8'hFF;
                        bus.rsp_ready  = 1'b1;
                    end
                    3: begin
                        bus.req0_valid = 1'b1; bus.req0_a = W'($urandom); bus.req0_b = W'($urandom);
                        bus.req1_valid = 1'b1; bus.req1_a = W'($urandom); bus.req1_b = W'($urandom);
                        bus.rsp_ready  = (stall > 5);
                    end
                    4: begin
                        bus.req0_valid = 1'b0; bus.req0_a = W'($urandom); bus.req0_b = W'($urandom);
                        bus.req1_valid = 1'b1; bus.req1_a = W'($urandom); bus.req1_b = W'($urandom);
                        bus.rsp_ready  = 1'b1;
                    end
                    5: begin
                        bus.req0_valid = 1'($urandom_range(0, 1));
                        bus.req1_valid = 1'($urandom_range(0, 1));
                        bus.req0_a = W'($urandom); bus.req0_b = W'($urandom);
                        bus.req1_a = W'($urandom); bus.req1_b = W'($urandom);
                        bus.rsp_ready = ($urandom_range(0, 3) != 0);
                    end
                    6: begin
                        bus.req0_valid = 1'b1; bus.req0_a = 8'h55; bus.req0_b = 8'h5A;
                        bus.req1_valid = 1'b0;
                        bus.rsp_ready  = 1'b1;
                    end
                    default: begin
                        bus.req0_valid = 1'b0;
                        bus.req1_valid = 1'b0;
                        bus.rsp_ready  = 1'b1;
                    end
                endcase
            end
        end

        // Outputs must clear as soon as reset is asserted, without a clock.
        initial forever begin
            @(negedge rst_n);
            #1;
            check({lt, ".async_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
            check({lt, ".async_dp_busy"},   32'(bus.dp_busy),   32'd0);
            check({lt, ".async_busy"},      32'(busy),          32'd0);
            check({lt, ".async_dp_a"},      32'(bus.dp_a),      32'd0);
            check({lt, ".async_rsp_data"},  32'(bus.rsp_data),  32'd0);
            check({lt, ".async_ready"},     32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        end

        // Reference model: one operation at a time; result is due L+1 cycles
        // after the grant cycle and stays until accepted.
        logic         m_busy;
        logic         m_ptr;
        logic         gid;
        logic [W-1:0] exp_a, exp_b, exp_y;
        logic         exp_id;
        int           cyc, due;

        initial begin
            m_busy = 1'b0; m_ptr = 1'b0; exp_a = '0; exp_b = '0; exp_y = '0;
            exp_id = 1'b0; cyc = 0; due = 0;
        end

        always @(negedge clk) begin
            if (!rst_n) begin
                check({lt, ".rst_ready"},     32'({bus.req0_ready, bus.req1_ready}), 32'd0);
                check({lt, ".rst_dp_a"},      32'(bus.dp_a),      32'd0);
                check({lt, ".rst_dp_b"},      32'(bus.dp_b),      32'd0);
                check({lt, ".rst_dp_busy"},   32'(bus.dp_busy),   32'd0);
                check({lt, ".rst_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
                check({lt, ".rst_rsp_data"},  32'(bus.rsp_data),  32'd0);
                check({lt, ".rst_rsp_id"},    32'(bus.rsp_id),    32'd0);
                check({lt, ".rst_busy"},      32'(busy),          32'd0);
                m_busy = 1'b0; m_ptr = 1'b0; exp_a = '0; exp_b = '0; cyc = 0;
            end else begin
                cyc++;
                if (!m_busy) begin
                    gid = (bus.req0_valid && bus.req1_valid) ? m_ptr : bus.req1_valid;
                    check({lt, ".req0_ready"}, 32'(bus.req0_ready),
                          32'(bus.req0_valid && (!bus.req1_valid || !m_ptr)));
                    check({lt, ".req1_ready"}, 32'(bus.req1_ready),
                          32'(bus.req1_valid && (!bus.req0_valid || m_ptr)));
                    check({lt, ".idle_busy"},      32'(busy),          32'd0);
                    check({lt, ".idle_dp_busy"},   32'(bus.dp_busy),   32'd0);
                    check({lt, ".idle_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
                    check({lt, ".idle_dp_a"},      32'(bus.dp_a),      32'(exp_a));
                    check({lt, ".idle_dp_b"},      32'(bus.dp_b),      32'(exp_b));
                    if (bus.req0_valid || bus.req1_valid) begin
                        exp_a  = gid ? bus.req1_a : bus.req0_a;
                        exp_b  = gid ? bus.req1_b : bus.req0_b;
                        exp_y  = exp_a & exp_b;
                        exp_id = gid;
                        m_ptr  = ~gid;
                        m_busy = 1'b1;
                        due    = cyc + L + 1;
                    end
                end else begin
                    check({lt, ".op_ready"}, 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
                    check({lt, ".op_busy"},  32'(busy),     32'd1);
                    check({lt, ".op_dp_a"},  32'(bus.dp_a), 32'(exp_a));
                    check({lt, ".op_dp_b"},  32'(bus.dp_b), 32'(exp_b));
                    if (cyc < due) begin
                        check({lt, ".wait_dp_busy"},   32'(bus.dp_busy),   32'd1);
                        check({lt, ".wait_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
                    end else begin
                        check({lt, ".resp_dp_busy"},   32'(bus.dp_busy),   32'd0);
                        check({lt, ".resp_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
                        check({lt, ".resp_rsp_data"},  32'(bus.rsp_data),  32'(exp_y));
                        check({lt, ".resp_rsp_id"},    32'(bus.rsp_id),    32'(exp_id));
                        if (bus.rsp_ready) m_busy = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        logic found;
        n_checks = 0;
        n_errors = 0;
        mode     = 1;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        repeat (12) @(posedge clk);
        mode = 0; repeat (6)  @(posedge clk);
        mode = 2; repeat (24) @(posedge clk);
        mode = 3; repeat (40) @(posedge clk);
        mode = 0; repeat (6)  @(posedge clk);
        mode = 4; repeat (30) @(posedge clk);
        mode = 0; repeat (6)  @(posedge clk);
        mode = 6; repeat (16) @(posedge clk);

        // Reset pulse while the LAT=3 lane is mid-operation.
        mode  = 4;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (lane[1].bus.dp_busy) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_wait", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        mode = 2;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);

        mode = 5; repeat (2000) @(posedge clk);
        mode = 0; repeat (12)   @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/and_unit_arbiter.md
Name: and_unit_arbiter

Overview:
Round-robin arbiter and sequencer that shares one WIDTH-bit bitwise logic datapath (the AND unit) between two requesters. Each requester presents an operand pair with a valid/ready handshake. The block issues the granted pair to the datapath, waits the datapath's fixed latency, then returns the registered result with the requester ID on a single valid/ready response channel. It sits between the top-level pin logic and the datapath instance.

Parameters:
WIDTH, 8, operand/result width in bits
LAT, 1, datapath latency in cycles from operands stable to dp_y valid; LAT >= 1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operand pair
req0_ready  out  1  requester 0 pair accepted this cycle
req0_a  in  WIDTH  requester 0 operand A
req0_b  in  WIDTH  requester 0 operand B
req1_valid  in  1  requester 1 has an operand pair
req1_ready  out  1  requester 1 pair accepted this cycle
req1_a  in  WIDTH  requester 1 operand A
req1_b  in  WIDTH  requester 1 operand B
dp_a  out  WIDTH  registered operand A to datapath
dp_b  out  WIDTH  registered operand B to datapath
dp_busy  out  1  high while the datapath holds an in-flight operation
dp_y  in  WIDTH  datapath result
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_data  out  WIDTH  registered result
rsp_id  out  1  ID of the requester that owns rsp_data
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, priority pointer=0, LAT counter=0. All outputs are 0: req*_ready, dp_a, dp_b, dp_busy, rsp_valid, rsp_data, rsp_id, busy. Any in-flight transaction is discarded with no response.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Grant is combinational. If only one reqN_valid is high, grant N. If both are high, grant the requester named by the priority pointer.
  - reqN_ready is high only in IDLE, for the granted requester, in the same cycle. This is the handshake cycle T.
  - At the T edge: dp_a/dp_b <= granted operands, rsp_id <= N, pointer <= ~N, counter <= LAT-1, state -> WAIT.
  - With no valid input, stay in IDLE with no change.
- WAIT:
  - dp_busy=1. dp_a/dp_b are held stable.
  - If counter != 0, decrement it.
  - If counter == 0: rsp_data <= dp_y, rsp_valid <= 1, dp_busy <= 0, state -> RESP.
  - Timing: dp_y is sampled at the end of cycle T+LAT, and rsp_valid is first high in cycle T+LAT+1.
- RESP:
  - rsp_valid, rsp_data and rsp_id are held stable until rsp_ready=1.
  - On the rsp_valid & rsp_ready edge: rsp_valid <= 0, state -> IDLE.
  - No new grant is issued in WAIT or RESP, so req*_ready=0 there. The earliest next handshake is the cycle after the response handshake.
  - Throughput is at most one operation per LAT+2 cycles.
- Fairness:
  - The pointer updates only on a grant.
  - A lone requester is always granted, independent of the pointer.
  - With both requesters continuously valid, grants strictly alternate.
- Requester rules:
  - A requester may drop valid without ever receiving ready; the arbiter re-evaluates every IDLE cycle.
  - Operands are captured only on the handshake edge, so later changes to reqN_a/reqN_b have no effect.
- dp_a/dp_b keep their last values after completion (no clear).
- rsp_ready asserted while rsp_valid=0 is ignored.
- All arithmetic is unsigned. The counter is $clog2(LAT+1) bits wide and never wraps, because it is reloaded on every grant.

Test Plan:
1. LAT=1, reset, then req0_valid=1 with a=0xF0, b=0x3C and rsp_ready=1 -> req0_ready=1 at T; rsp_valid=1, rsp_data=0x30, rsp_id=0 at T+2; busy low at T+3.
2. Both requesters valid from reset (req0 a=0xFF b=0x0F; req1 a=0xAA b=0xFF), rsp_ready=1 -> responses 0x0F/id0, 0xAA/id1, 0x0F/id0, 0xAA/id1; grants spaced 3 cycles apart.
3. rsp_ready=0 for 5 cycles after rsp_valid rises -> rsp_data/rsp_id stable, req*_ready stay 0; rsp_ready=1 -> rsp_valid falls next cycle, next grant the cycle after.
4. Only req1 valid for 4 consecutive operations -> 4 grants to req1, each rsp_id=1, no idle gap beyond LAT+2.
5. rst_n pulsed low mid-WAIT -> all outputs are 0 immediately (asynchronous), no response is produced; the next request after release completes normally with pointer=0.
6. LAT=3 build, req0 a=0x55 b=0x5A -> dp_busy high for 3 cycles, rsp_valid at T+4, rsp_data=0x50.
